// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and the angle sequencer state type.
package cordic_pkg;

  localparam int ANGLE_W_DEF = 17;
  localparam int unsigned FULL_TURN = 2 ** ANGLE_W_DEF;
  localparam int CORDIC_LAT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } seq_state_t;

endpackage

// File: rtl/cordic_phase_acc.sv
// Loadable modulo-2^W phase accumulator.
// The step is captured on load, so the accumulator owns the whole sweep.
module cordic_phase_acc
  import cordic_pkg::*;
#(
  parameter int W = ANGLE_W_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Load,
  input  logic         En,
  input  logic [W-1:0] Load_val,
  input  logic [W-1:0] Step,
  output logic [W-1:0] Acc
);

  logic [W-1:0] step_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Acc    <= '0;
      step_q <= '0;
    end else if (Load) begin
      Acc    <= Load_val;
      step_q <= Step;
    end else if (En) begin
      Acc    <= Acc + step_q;
    end
  end

endmodule

// File: rtl/cordic_angle_seq.sv
// Angle burst sequencer feeding the CORDIC core, with drain and Done.
// CORDIC_ANGLE_SEQ_CONT_EN: Count=0 starts a continuous sweep until Stop.
module cordic_angle_seq
  import cordic_pkg::*;
#(
  parameter int CORDIC_LATENCY = CORDIC_LAT_DEF,
  parameter int ANGLE_W        = ANGLE_W_DEF,
  parameter int COUNT_W        = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stop,
  input  logic [ANGLE_W-1:0] Start_angle,
  input  logic [ANGLE_W-1:0] Step,
  input  logic [COUNT_W-1:0] Count,
  output logic [ANGLE_W-1:0] Input_angle,
  output logic               Angle_valid,
  output logic               Busy,
  output logic               Done
);

`ifdef CORDIC_ANGLE_SEQ_CONT_EN
  localparam logic CONT_EN = 1'b1;
`else
  localparam logic CONT_EN = 1'b0;
`endif

  localparam logic [7:0] LAT_INIT = 8'(CORDIC_LATENCY - 1);

  seq_state_t         state, state_d;
  logic [COUNT_W-1:0] rem, rem_d;
  logic [7:0]         lat, lat_d;
  logic               cont, cont_d;
  logic               valid_d, done_d;
  logic               load, adv;

  cordic_phase_acc #(.W(ANGLE_W)) u_acc (
    .Clk      (Clk),
    .Reset    (Reset),
    .Load     (load),
    .En       (adv),
    .Load_val (Start_angle),
    .Step     (Step),
    .Acc      (Input_angle)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      rem         <= '0;
      lat         <= '0;
      cont        <= 1'b0;
      Angle_valid <= 1'b0;
      Done        <= 1'b0;
    end else begin
      state       <= state_d;
      rem         <= rem_d;
      lat         <= lat_d;
      cont        <= cont_d;
      Angle_valid <= valid_d;
      Done        <= done_d;
    end
  end

  // rem counts angles still to issue after the one on the output now
  always_comb begin
    state_d = state;
    rem_d   = rem;
    lat_d   = lat;
    cont_d  = cont;
    valid_d = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (Start && !Stop && ((Count != '0) || CONT_EN)) begin
          state_d = ST_RUN;
          load    = 1'b1;
          valid_d = 1'b1;
          rem_d   = Count - COUNT_W'(1);
          cont_d  = (Count == '0);
        end
      end
      ST_RUN: begin
        if (Stop || (!cont && (rem == '0))) begin
          state_d = ST_DRAIN;
          lat_d   = LAT_INIT;
        end else begin
          adv     = 1'b1;
          valid_d = 1'b1;
          rem_d   = rem - COUNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (lat == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          lat_d = lat - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cordic_angle_seq.sv
// Directed bench for cordic_angle_seq with hand-computed angle sequences.
// Define CORDIC_ANGLE_SEQ_CONT_EN to exercise the continuous sweep instead.
module tb_cordic_angle_seq;
  import cordic_pkg::*;

  localparam int LAT = CORDIC_LAT_DEF;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Stop;
  logic [16:0] Start_angle;
  logic [16:0] Step;
  logic [15:0] Count;
  logic [16:0] Input_angle;
  logic        Angle_valid;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int errors = 0;

  cordic_angle_seq #(
    .CORDIC_LATENCY (LAT),
    .ANGLE_W        (17),
    .COUNT_W        (16)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Stop        (Stop),
    .Start_angle (Start_angle),
    .Step        (Step),
    .Count       (Count),
    .Input_angle (Input_angle),
    .Angle_valid (Angle_valid),
    .Busy        (Busy),
    .Done        (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_angle(input string tag, input logic [16:0] exp);
    chk({tag, "_v"}, 32'(Angle_valid), 32'd1);
    chk({tag, "_a"}, 32'(Input_angle), 32'(exp));
  endtask

  // Called in the first DRAIN cycle; Done is due LAT cycles later.
  task automatic drain_check(input string tag);
    int k;
    k = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      step();
      if (Done) begin
        k = i;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(k), 32'(LAT));
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    step();
    chk({tag, "_pulse"}, 32'(Done), 32'd0);
  endtask

  initial begin
    Reset       = 1'b1;
    Start       = 1'b0;
    Stop        = 1'b0;
    Start_angle = '0;
    Step        = '0;
    Count       = '0;
    step();
    step();
    chk("rst_angle", 32'(Input_angle), 32'd0);
    chk("rst_valid", 32'(Angle_valid), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    Reset = 1'b0;
    step();

    // basic burst
    Start_angle = 17'h00000;
    Step        = 17'h00100;
    Count       = 16'd4;
    Start       = 1'b1;
    step();
    Start = 1'b0;
    chk_angle("b0", 17'h00000);
    chk("b_busy", 32'(Busy), 32'd1);
    step();
    chk_angle("b1", 17'h00100);
    step();
    chk_angle("b2", 17'h00200);
    step();
    chk_angle("b3", 17'h00300);
    step();
    chk("b_end_v", 32'(Angle_valid), 32'd0);
    chk("b_hold", 32'(Input_angle), 32'h00300);
    drain_check("b");

    // wrap-around, with a Start during RUN that must be ignored
    Start_angle = 17'h1FF00;
    Step        = 17'h00200;
    Count       = 16'd3;
    Start       = 1'b1;
    step();
    Start_angle = 17'h12345;
    Step        = 17'h00001;
    Count       = 16'd100;
    chk_angle("w0", 17'h1FF00);
    step();
    Start = 1'b0;
    chk_angle("w1", 17'h00100);
    step();
    chk_angle("w2", 17'h00300);
    step();
    chk("w_end_v", 32'(Angle_valid), 32'd0);
    drain_check("w");

    // stop with the 3rd angle
    Start_angle = 17'h00010;
    Step        = 17'h00010;
    Count       = 16'd10;
    Start       = 1'b1;
    step();
    Start = 1'b0;
    chk_angle("s0", 17'h00010);
    step();
    chk_angle("s1", 17'h00020);
    step();
    chk_angle("s2", 17'h00030);
    Stop = 1'b1;
    step();
    chk("s_end_v", 32'(Angle_valid), 32'd0);
    chk("s_hold", 32'(Input_angle), 32'h00030);
    chk("s_busy", 32'(Busy), 32'd1);
    drain_check("s");
    Stop = 1'b0;

    // Start together with Stop in IDLE
    Start_angle = 17'h00777;
    Count       = 16'd5;
    Start       = 1'b1;
    Stop        = 1'b1;
    step();
    Start = 1'b0;
    Stop  = 1'b0;
    chk("ss_busy", 32'(Busy), 32'd0);
    chk("ss_valid", 32'(Angle_valid), 32'd0);
    step();

`ifdef CORDIC_ANGLE_SEQ_CONT_EN
    // continuous sweep until Stop
    Start_angle = 17'h00000;
    Step        = 17'h08000;
    Count       = 16'd0;
    Start       = 1'b1;
    step();
    Start = 1'b0;
    chk_angle("c0", 17'h00000);
    step();
    chk_angle("c1", 17'h08000);
    step();
    chk_angle("c2", 17'h10000);
    step();
    chk_angle("c3", 17'h18000);
    step();
    chk_angle("c4", 17'h00000);
    step();
    chk_angle("c5", 17'h08000);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    chk("c_end_v", 32'(Angle_valid), 32'd0);
    drain_check("c");
`else
    // Count=0 is ignored
    Count = 16'd0;
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("z_busy", 32'(Busy), 32'd0);
    chk("z_valid", 32'(Angle_valid), 32'd0);
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      chk("z_done", 32'(Done), 32'd0);
    end
`endif

    // reset five cycles into DRAIN
    Start_angle = 17'h05555;
    Step        = 17'h00001;
    Count       = 16'd2;
    Start       = 1'b1;
    step();
    Start = 1'b0;
    chk_angle("r0", 17'h05555);
    step();
    chk_angle("r1", 17'h05556);
    for (int i = 0; i < 5; i++) step();
    chk("r_busy_pre", 32'(Busy), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("r_angle", 32'(Input_angle), 32'd0);
    chk("r_busy", 32'(Busy), 32'd0);
    chk("r_valid", 32'(Angle_valid), 32'd0);
    step();
    Reset = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      chk("r_nodone", 32'(Done), 32'd0);
    end

    // single-angle burst after reset
    Start_angle = 17'h0ABCD;
    Count       = 16'd1;
    Start       = 1'b1;
    step();
    Start = 1'b0;
    chk_angle("p0", 17'h0ABCD);
    step();
    chk("p_end_v", 32'(Angle_valid), 32'd0);
    drain_check("p");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
